// File: rtl/nway_wb_cache_pkg.sv
// Shared cache types: controller state encoding and tree-PLRU helpers.
// The helpers take the way count as an argument so one copy serves any associativity up to 64 ways.
package cache_types;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPARE   = 2'd1,
        WRITEBACK = 2'd2,
        FETCH     = 2'd3
    } cache_state_e;

    localparam int PLRU_MAX_W   = 63;
    localparam int PLRU_MAX_LVL = 6;

    // Walk from the root: a 0 bit sends the victim search to the lower half, a 1 to the upper half.
    function automatic logic [6:0] plru_victim(input logic [PLRU_MAX_W-1:0] bits,
                                               input logic [6:0] ways);
        logic [5:0] node;
        logic [6:0] lo;
        logic [6:0] span;
        logic [6:0] half;
        node = 6'd0;
        lo   = 7'd0;
        span = ways;
        half = 7'd0;
        for (int lvl = 0; lvl < PLRU_MAX_LVL; lvl++) begin
            if (span > 7'd1) begin
                half = span >> 1;
                if (bits[node] == 1'b0) begin
                    node = {node[4:0], 1'b0} + 6'd1;
                end else begin
                    node = {node[4:0], 1'b0} + 6'd2;
                    lo   = lo + half;
                end
                span = half;
            end else begin
                span = span;
            end
        end
        return lo;
    endfunction

    // Every node on the accessed way's path is pointed away from that way.
    function automatic logic [PLRU_MAX_W-1:0] plru_update(input logic [PLRU_MAX_W-1:0] bits_in,
                                                          input logic [6:0] way,
                                                          input logic [6:0] ways);
        logic [PLRU_MAX_W-1:0] bits;
        logic [5:0] node;
        logic [6:0] lo;
        logic [6:0] span;
        logic [6:0] half;
        bits = bits_in;
        node = 6'd0;
        lo   = 7'd0;
        span = ways;
        half = 7'd0;
        for (int lvl = 0; lvl < PLRU_MAX_LVL; lvl++) begin
            if (span > 7'd1) begin
                half = span >> 1;
                if (way < lo + half) begin
                    bits[node] = 1'b1;
                    node       = {node[4:0], 1'b0} + 6'd1;
                end else begin
                    bits[node] = 1'b0;
                    node       = {node[4:0], 1'b0} + 6'd2;
                    lo         = lo + half;
                end
                span = half;
            end else begin
                span = span;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/nway_wb_cache_plru_tree.sv
// Per-set tree-PLRU bit storage: presents the victim for the addressed set and
// records accesses reported by the controller.
module plru_tree
    import cache_types::*;
#(
    parameter int num_ways = 4,
    parameter int num_sets = 8,
    parameter int s_index  = 3
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [s_index-1:0]          index,
    input  logic                        upd_en,
    input  logic [$clog2(num_ways)-1:0] upd_way,
    output logic [$clog2(num_ways)-1:0] victim
);

    localparam int s_way  = $clog2(num_ways);
    localparam int s_bits = num_ways - 1;

    logic [s_bits-1:0] bits_q [num_sets];
    logic [s_bits-1:0] bits_d [num_sets];

    always_comb begin
        bits_d = bits_q;
        if (upd_en) begin
            bits_d[index] = s_bits'(plru_update(PLRU_MAX_W'(bits_q[index]), 7'(upd_way), 7'(num_ways)));
        end else begin
            bits_d[index] = bits_q[index];
        end
        victim = s_way'(plru_victim(PLRU_MAX_W'(bits_q[index]), 7'(num_ways)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bits_q <= '{default: '0};
        end else begin
            bits_q <= bits_d;
        end
    end

endmodule

// File: rtl/nway_wb_cache.sv
// N-way set-associative write-back cache with flop arrays and a four-state controller.
// Define CACHE_PERF_COUNTERS_EN to add saturating hit/miss/writeback counters.
module nway_wb_cache
    import cache_types::*;
#(
    parameter int s_offset = 5,
    parameter int s_index  = 3,
    parameter int num_ways = 4,
    parameter int s_tag    = 32 - s_offset - s_index
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               mem_address,
    input  logic                      mem_read,
    input  logic                      mem_write,
    input  logic [2**s_offset-1:0]    mem_byte_enable256,
    input  logic [8*2**s_offset-1:0]  mem_wdata256,
    output logic [8*2**s_offset-1:0]  mem_rdata256,
    output logic                      mem_resp,
    output logic [31:0]               pmem_address,
    output logic                      pmem_read,
    output logic                      pmem_write,
    output logic [8*2**s_offset-1:0]  pmem_wdata,
    input  logic [8*2**s_offset-1:0]  pmem_rdata,
    input  logic                      pmem_resp
`ifdef CACHE_PERF_COUNTERS_EN
    ,
    output logic [31:0]               hit_count,
    output logic [31:0]               miss_count,
    output logic [31:0]               wb_count
`endif
);

    localparam int s_line   = 8 * 2**s_offset;
    localparam int s_be     = 2**s_offset;
    localparam int num_sets = 2**s_index;
    localparam int s_way    = $clog2(num_ways);
    localparam int s_laddr  = 32 - s_offset;

    function automatic logic [s_line-1:0] merge_line(input logic [s_line-1:0] old_line,
                                                     input logic [s_line-1:0] new_line,
                                                     input logic [s_be-1:0]   be);
        logic [s_line-1:0] res;
        for (int i = 0; i < s_be; i++) begin
            res[8*i +: 8] = be[i] ? new_line[8*i +: 8] : old_line[8*i +: 8];
        end
        return res;
    endfunction

    cache_state_e        state_q, state_d;
    logic [s_laddr-1:0]  laddr_q, laddr_d;
    logic [s_be-1:0]     be_q, be_d;
    logic [s_line-1:0]   wdata_q, wdata_d;
    logic                write_q, write_d;
    logic                refill_q, refill_d;
    logic [s_way-1:0]    victim_q, victim_d;

    logic [s_tag-1:0]    tag_q   [num_sets][num_ways];
    logic [s_tag-1:0]    tag_d   [num_sets][num_ways];
    logic [s_line-1:0]   data_q  [num_sets][num_ways];
    logic [s_line-1:0]   data_d  [num_sets][num_ways];
    logic [num_ways-1:0] valid_q [num_sets];
    logic [num_ways-1:0] valid_d [num_sets];
    logic [num_ways-1:0] dirty_q [num_sets];
    logic [num_ways-1:0] dirty_d [num_sets];

    logic [s_index-1:0]  idx;
    logic [s_tag-1:0]    req_tag;
    logic                hit;
    logic [s_way-1:0]    hit_way;
    logic                any_inv;
    logic [s_way-1:0]    inv_way;
    logic [s_way-1:0]    plru_way;
    logic [s_way-1:0]    alloc_way;

    assign idx     = laddr_q[s_index-1:0];
    assign req_tag = laddr_q[s_laddr-1:s_index];

    // Lookup of the latched set; the descending scan leaves the lowest invalid way selected.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        any_inv = 1'b0;
        inv_way = '0;
        for (int w = 0; w < num_ways; w++) begin
            if (valid_q[idx][w] && (tag_q[idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = s_way'(w);
            end else begin
                hit = hit;
            end
        end
        for (int w = num_ways - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) begin
                any_inv = 1'b1;
                inv_way = s_way'(w);
            end else begin
                any_inv = any_inv;
            end
        end
        alloc_way = any_inv ? inv_way : plru_way;
    end

    plru_tree #(
        .num_ways (num_ways),
        .num_sets (num_sets),
        .s_index  (s_index)
    ) u_plru (
        .clk     (clk),
        .rst     (rst),
        .index   (idx),
        .upd_en  ((state_q == COMPARE) && hit),
        .upd_way (hit_way),
        .victim  (plru_way)
    );

    // Controller next state and array updates.
    always_comb begin
        state_d  = state_q;
        laddr_d  = laddr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        write_d  = write_q;
        refill_d = refill_q;
        victim_d = victim_q;
        tag_d    = tag_q;
        data_d   = data_q;
        valid_d  = valid_q;
        dirty_d  = dirty_q;
        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    laddr_d  = mem_address[31:s_offset];
                    be_d     = mem_byte_enable256;
                    wdata_d  = mem_wdata256;
                    write_d  = mem_write;
                    refill_d = 1'b0;
                    state_d  = COMPARE;
                end else begin
                    state_d = IDLE;
                end
            end
            COMPARE: begin
                if (hit) begin
                    state_d = IDLE;
                    if (write_q) begin
                        data_d[idx][hit_way]  = merge_line(data_q[idx][hit_way], wdata_q, be_q);
                        dirty_d[idx][hit_way] = 1'b1;
                    end else begin
                        dirty_d[idx][hit_way] = dirty_q[idx][hit_way];
                    end
                end else begin
                    victim_d = alloc_way;
                    if (valid_q[idx][alloc_way] && dirty_q[idx][alloc_way]) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            WRITEBACK: begin
                if (pmem_resp) begin
                    state_d = FETCH;
                end else begin
                    state_d = WRITEBACK;
                end
            end
            FETCH: begin
                if (pmem_resp) begin
                    tag_d[idx][victim_q]   = req_tag;
                    data_d[idx][victim_q]  = pmem_rdata;
                    valid_d[idx][victim_q] = 1'b1;
                    dirty_d[idx][victim_q] = 1'b0;
                    refill_d               = 1'b1;
                    state_d                = COMPARE;
                end else begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory-side outputs depend only on state so they hold steady while waiting.
    always_comb begin
        mem_resp     = (state_q == COMPARE) && hit;
        mem_rdata256 = data_q[idx][hit_way];
        pmem_wdata   = data_q[idx][victim_q];
        case (state_q)
            WRITEBACK: begin
                pmem_read    = 1'b0;
                pmem_write   = 1'b1;
                pmem_address = {tag_q[idx][victim_q], idx, {s_offset{1'b0}}};
            end
            FETCH: begin
                pmem_read    = 1'b1;
                pmem_write   = 1'b0;
                pmem_address = {laddr_q, {s_offset{1'b0}}};
            end
            default: begin
                pmem_read    = 1'b0;
                pmem_write   = 1'b0;
                pmem_address = {laddr_q, {s_offset{1'b0}}};
            end
        endcase
    end

    // Control and status state; tag/data contents need no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            refill_q <= 1'b0;
            victim_q <= '0;
            valid_q  <= '{default: '0};
            dirty_q  <= '{default: '0};
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            refill_q <= refill_d;
            victim_q <= victim_d;
            valid_q  <= valid_d;
            dirty_q  <= dirty_d;
        end
    end

    // Request latch and line storage.
    always_ff @(posedge clk) begin
        laddr_q <= laddr_d;
        be_q    <= be_d;
        wdata_q <= wdata_d;
        tag_q   <= tag_d;
        data_q  <= data_d;
    end

`ifdef CACHE_PERF_COUNTERS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;
    logic [31:0] wb_count_q, wb_count_d;

    // The post-fill re-compare is excluded from hits via refill_q.
    always_comb begin
        if ((state_q == COMPARE) && hit && !refill_q && (hit_count_q != 32'hFFFF_FFFF)) begin
            hit_count_d = hit_count_q + 32'd1;
        end else begin
            hit_count_d = hit_count_q;
        end
        if ((state_q == COMPARE) && !hit && (miss_count_q != 32'hFFFF_FFFF)) begin
            miss_count_d = miss_count_q + 32'd1;
        end else begin
            miss_count_d = miss_count_q;
        end
        if ((state_q == WRITEBACK) && pmem_resp && (wb_count_q != 32'hFFFF_FFFF)) begin
            wb_count_d = wb_count_q + 32'd1;
        end else begin
            wb_count_d = wb_count_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_q  <= 32'd0;
            miss_count_q <= 32'd0;
            wb_count_q   <= 32'd0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            wb_count_q   <= wb_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
    assign wb_count   = wb_count_q;
`endif

endmodule

// File: tb/tb_nway_wb_cache.sv
// Directed bench for nway_wb_cache: a transparent-memory model predicts every read line and
// writeback payload; hand-computed pmem address sequences pin allocation and PLRU choices.
module tb_nway_wb_cache;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_byte_enable256;
    logic [255:0] mem_wdata256;
    logic [255:0] mem_rdata256;
    logic         mem_resp;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
`ifdef CACHE_PERF_COUNTERS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
    logic [31:0]  wb_count;
`endif

    nway_wb_cache dut (
        .clk                (clk),
        .rst                (rst),
        .mem_address        (mem_address),
        .mem_read           (mem_read),
        .mem_write          (mem_write),
        .mem_byte_enable256 (mem_byte_enable256),
        .mem_wdata256       (mem_wdata256),
        .mem_rdata256       (mem_rdata256),
        .mem_resp           (mem_resp),
        .pmem_address       (pmem_address),
        .pmem_read          (pmem_read),
        .pmem_write         (pmem_write),
        .pmem_wdata         (pmem_wdata),
        .pmem_rdata         (pmem_rdata),
        .pmem_resp          (pmem_resp)
`ifdef CACHE_PERF_COUNTERS_EN
        ,
        .hit_count          (hit_count),
        .miss_count         (miss_count),
        .wb_count           (wb_count)
`endif
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Physical memory and the CPU-visible view (lines written by the CPU since the last reset).
    logic [255:0] phys [logic [31:0]];
    logic [255:0] view [logic [31:0]];
    logic [32:0]  txn_q [$];

    int           resp_delay  = 3;
    bit           resp_en     = 1'b1;
    bit           stray_pulse = 1'b0;
    bit           req_active  = 1'b0;
    bit           req_wr      = 1'b0;
    bit           resp_seen   = 1'b0;
    logic [31:0]  req_addr    = 32'd0;
    logic [31:0]  req_be      = 32'd0;
    logic [255:0] req_wdata   = 256'd0;
    logic [255:0] last_rdata  = 256'd0;
    logic [255:0] last_wb     = 256'd0;
    int           lat;

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return {a[31:5], 5'b0};
    endfunction

    function automatic logic [255:0] get_phys(input logic [31:0] a);
        logic [31:0] l;
        l = line_of(a);
        if (phys.exists(l)) return phys[l];
        return {8{l ^ 32'h5A5A_0000}};
    endfunction

    function automatic logic [255:0] get_view(input logic [31:0] a);
        logic [31:0] l;
        l = line_of(a);
        if (view.exists(l)) return view[l];
        return get_phys(l);
    endfunction

    function automatic logic [255:0] merge(input logic [255:0] old_line, input logic [255:0] wd,
                                           input logic [31:0] be);
        logic [255:0] r;
        r = old_line;
        for (int i = 0; i < 32; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic chk_txn(input string nm, input bit wr, input logic [31:0] a);
        logic [32:0] t;
        if (txn_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s: got no pmem transaction expected wr=%0d addr=%h", nm, wr, a);
        end else begin
            t = txn_q.pop_front();
            chk(nm, 256'(t), 256'({wr, a}));
        end
    endtask

    task automatic chk_none(input string nm);
        chk(nm, 256'(txn_q.size()), 256'(0));
        txn_q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; req_active = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        view.delete();
        txn_q.delete();
    endtask

    // Issue one request and wait (bounded) for mem_resp; lt counts cycles after the sampling edge.
    task automatic do_req(input logic [31:0] a, input bit wr, input bit both, input logic [31:0] be,
                          input logic [255:0] wd, output int lt);
        @(posedge clk); #1;
        req_addr = a; req_wr = wr; req_be = be; req_wdata = wd;
        resp_seen = 1'b0; req_active = 1'b1;
        mem_address = a; mem_byte_enable256 = be; mem_wdata256 = wd;
        mem_write = wr; mem_read = !wr || both;
        lt = 0;
        while (lt < 300) begin
            @(negedge clk); #1;
            if (resp_seen) break;
            lt++;
        end
        if (!resp_seen) chk("req_timeout", 256'(resp_seen), 256'(1));
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0; req_active = 1'b0;
    endtask

    // Physical memory responder.
    initial begin
        int busy;
        busy = 0;
        pmem_resp = 1'b0;
        pmem_rdata = 256'd0;
        forever begin
            @(negedge clk);
            if (stray_pulse) begin
                pmem_resp = 1'b1; stray_pulse = 1'b0; busy = 0;
            end else if (resp_en && !rst && (pmem_read || pmem_write) && !pmem_resp) begin
                busy++;
                if (busy >= resp_delay) begin
                    busy = 0;
                    pmem_resp = 1'b1;
                    txn_q.push_back({pmem_write, pmem_address});
                    if (pmem_write) begin
                        last_wb = pmem_wdata;
                        phys[line_of(pmem_address)] = get_view(pmem_address);
                    end else begin
                        pmem_rdata = get_phys(pmem_address);
                    end
                end
            end else begin
                pmem_resp = 1'b0;
                busy = 0;
            end
        end
    end

    // Cycle-by-cycle compare of DUT outputs against the model.
    initial begin
        bit prev_resp;
        prev_resp = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("pmem_exclusive", 256'(pmem_read & pmem_write), 256'(0));
                if (mem_resp) begin
                    chk("resp_single_cycle", 256'(prev_resp), 256'(0));
                    chk("resp_has_request", 256'(req_active), 256'(1));
                    if (req_active && !req_wr) begin
                        chk("read_data", mem_rdata256, get_view(req_addr));
                        last_rdata = mem_rdata256;
                    end else if (req_active) begin
                        view[line_of(req_addr)] = merge(get_view(req_addr), req_wdata, req_be);
                    end
                    resp_seen = 1'b1;
                end
                if (pmem_write) chk("writeback_data", pmem_wdata, get_view(pmem_address));
                if (pmem_read || pmem_write) chk("pmem_line_aligned", 256'(pmem_address[4:0]), 256'(0));
                prev_resp = mem_resp;
            end else begin
                prev_resp = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int t;
        rst = 1'b0; mem_address = 32'd0; mem_read = 1'b0; mem_write = 1'b0;
        mem_byte_enable256 = 32'd0; mem_wdata256 = 256'd0;
        phys[32'h0000_0020] = {32{8'hA5}};

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_mem_resp", 256'(mem_resp), 256'(0));
        chk("rst_pmem_read", 256'(pmem_read), 256'(0));
        chk("rst_pmem_write", 256'(pmem_write), 256'(0));
        do_req(32'h0000_0040, 1'b0, 1'b0, 32'd0, 256'd0, lat);
        chk_txn("rst_read_miss_addr", 1'b0, 32'h0000_0040);
        chk_none("rst_read_miss_only");

        // Cold miss then hit
        do_req(32'h0000_0020, 1'b0, 1'b0, 32'd0, 256'd0, lat);
        chk("cold_miss_latency", 256'(lat), 256'(5));
        chk("cold_miss_data", last_rdata, {32{8'hA5}});
        chk_txn("cold_miss_fetch", 1'b0, 32'h0000_0020);
        chk_none("cold_miss_only");
        do_req(32'h0000_0020, 1'b0, 1'b0, 32'd0, 256'd0, lat);
        chk("read_hit_latency", 256'(lat), 256'(1));
        chk_none("read_hit_no_pmem");

        // Byte-enabled write hit (read and write both high counts as a write)
        do_req(32'h0000_0020, 1'b1, 1'b1, 32'h0000_0001, {{31{8'hEE}}, 8'h5C}, lat);
        chk("write_hit_latency", 256'(lat), 256'(1));
        chk_none("write_hit_no_pmem");
        do_req(32'h0000_0020, 1'b0, 1'b0, 32'd0, 256'd0, lat);
        chk("write_hit_readback", last_rdata, {{31{8'hA5}}, 8'h5C});

        // Dirty eviction in set 0
        resp_delay = 1;
        do_req(32'h0000_0100, 1'b0, 1'b0, 32'd0, 256'd0, lat);
        chk_txn("fill_tag1", 1'b0, 32'h0000_0100);
        do_req(32'h0000_0100, 1'b1, 1'b0, 32'hF000_0000, {32{8'h3C}}, lat);
        chk_none("dirty_tag1_hit");
        do_req(32'h0000_0200, 1'b0, 1'b0, 32'd0, 256'd0, lat);
        chk_txn("fill_tag2", 1'b0, 32'h0000_0200);
        do_req(32'h0000_0300, 1'b0, 1'b0, 32'd0, 256'd0, lat);
        chk_txn("fill_tag3", 1'b0, 32'h0000_0300);
        do_req(32'h0000_0400, 1'b0, 1'b0, 32'd0, 256'd0, lat);
        chk_txn("fill_tag4", 1'b0, 32'h0000_0400);
        do_req(32'h0000_0500, 1'b0, 1'b0, 32'd0, 256'd0, lat);
        chk_txn("evict_writeback_tag1", 1'b1, 32'h0000_0100);
        chk_txn("evict_fetch_tag5", 1'b0, 32'h0000_0500);
        chk_none("evict_only_two");
        chk("evict_wb_payload", last_wb, {32'h3C3C_3C3C, {7{32'h5A5A_0100}}});

        // PLRU: touch ways 0..3 then way 0 again; victim must be way 2 (tag 3)
        resp_delay = 2;
        do_req(32'h0000_0500, 1'b0, 1'b0, 32'd0, 256'd0, lat);
        do_req(32'h0000_0200, 1'b0, 1'b0, 32'd0, 256'd0, lat);
        do_req(32'h0000_0300, 1'b0, 1'b0, 32'd0, 256'd0, lat);
        do_req(32'h0000_0400, 1'b0, 1'b0, 32'd0, 256'd0, lat);
        do_req(32'h0000_0500, 1'b0, 1'b0, 32'd0, 256'd0, lat);
        chk_none("plru_all_hits");
        do_req(32'h0000_0600, 1'b0, 1'b0, 32'd0, 256'd0, lat);
        chk_txn("plru_fetch_tag6", 1'b0, 32'h0000_0600);
        chk_none("plru_clean_victim");
        do_req(32'h0000_0300, 1'b0, 1'b0, 32'd0, 256'd0, lat);
        chk_txn("plru_tag3_evicted", 1'b0, 32'h0000_0300);
        chk_none("plru_tag3_refill_only");
        do_req(32'h0000_0500, 1'b0, 1'b0, 32'd0, 256'd0, lat);
        do_req(32'h0000_0400, 1'b0, 1'b0, 32'd0, 256'd0, lat);
        chk_none("plru_tag5_tag4_resident");

        // Reset in the middle of a fill
        resp_en = 1'b0;
        @(posedge clk); #1;
        req_addr = 32'h0000_0700; req_wr = 1'b0; req_active = 1'b1;
        mem_address = 32'h0000_0700; mem_read = 1'b1;
        t = 0;
        while (!pmem_read && t < 20) begin
            @(negedge clk); #1;
            t++;
        end
        chk("midfill_pmem_read", 256'(pmem_read), 256'(1));
        chk("midfill_pmem_addr", 256'(pmem_address), 256'(32'h0000_0700));
        @(posedge clk); #1;
        rst = 1'b1; mem_read = 1'b0; req_active = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midfill_rst_drops_read", 256'(pmem_read), 256'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        view.delete();
        txn_q.delete();
        stray_pulse = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            chk("stray_resp_ignored", 256'({pmem_read, pmem_write, mem_resp}), 256'(0));
        end
        resp_en = 1'b1;
        do_req(32'h0000_0700, 1'b0, 1'b0, 32'd0, 256'd0, lat);
        chk_txn("post_rst_miss_again", 1'b0, 32'h0000_0700);
        chk_none("post_rst_no_writeback");
        do_req(32'h0000_0020, 1'b0, 1'b0, 32'd0, 256'd0, lat);
        chk_txn("post_rst_dirty_lost_fetch", 1'b0, 32'h0000_0020);
        chk("post_rst_dirty_lost_data", last_rdata, {32{8'hA5}});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
